mem_datos_arbiter: RTL and testbench
====================================

# mem_datos_arbiter

Two-port arbiter that shares the single-port data memory (Mem_Datos) between the RISC-V load/store unit (port 0) and a secondary master such as a program loader or DMA (port 1). It serialises requests, drives the memory's Address/WriteData/Write_EN from registered values, captures read data, and returns per-port completion and error status. It sits between the core's memory stage and Mem_Datos, which is instantiated beside it.

## Interface
- ADDR_W, 32, requester and memory address width (word address)
- DATA_W, 32, data width
- MEM_WORDS, 256, number of implemented words; any address >= MEM_WORDS is out of range
- CLK  in  1  clock, all logic on rising edge
- RST  in  1  synchronous, active-high reset
- req0/req1  in  1  access request, held until gnt of that port
- we0/we1  in  1  1 = write, 0 = read; stable while req high
- addr0/addr1  in  ADDR_W  word address; stable while req high
- wdata0/wdata1  in  DATA_W  write data; stable while req high
- gnt0/gnt1  out  1  one-cycle grant pulse; requester drops or changes req next cycle
- rvalid0/rvalid1  out  1  one-cycle completion pulse (reads and writes)
- rdata0/rdata1  out  DATA_W  read data, valid with rvalid on reads; 0 otherwise
- err0/err1  out  1  out-of-range flag, valid with rvalid
- mem_addr  out  ADDR_W  to Mem_Datos Address
- mem_wdata  out  DATA_W  to Mem_Datos WriteData
- mem_we  out  1  to Mem_Datos Write_EN
- mem_rdata  in  DATA_W  from Mem_Datos Read_Data (combinational read)

## Operation
- FSM states: IDLE, BUSY, RESP.
- IDLE: if req0|req1, pick winner, latch its we/addr/wdata and port id, go BUSY; else stay.
- BUSY: the gnt of the winner is high; mem_addr/mem_wdata show the latched values; mem_we = latched we AND in-range. The memory writes on the closing edge. mem_rdata is registered into rdata_q at the closing edge. Go to RESP.
- RESP: the winner's rvalid is high. The winner's rdata shows rdata_q on an in-range read; it is 0 on writes and on errors. The winner's err is high if the address was out of range. Requests are sampled the same as in IDLE: if any req, go to BUSY with the new winner; else go to IDLE.
- Out-of-range access: memory is never written; the read returns 0; err = 1.
- Arbitration with one request: that port wins. With both requesting: see Configuration.
- Outputs for the non-winning port stay 0 in every state.
- mem_addr, mem_wdata and mem_we are 0 outside BUSY.

## Timing
- Request sampled at edge E0. gnt is high in cycle E0..E1. rvalid is high in cycle E1..E2.
- Latency: 2 cycles from sampled req to rvalid.
- Throughput: 1 transaction per 2 cycles. Back-to-back goes RESP→BUSY with no IDLE cycle.
- Requesters must deassert or update req in the cycle after gnt. A req still high in RESP is treated as a new request.
- Reset values: state IDLE; all gnt/rvalid/err/rdata 0; mem_* 0; rdata_q 0; last-grant pointer = 1.
- RST during BUSY: a write presented in that cycle still commits at that edge. No rvalid is issued, and the FSM is in IDLE next cycle.
- RST during RESP: the rvalid pulse for that cycle is still visible. All outputs are 0 from the next cycle.

## Configuration
- MEM_ARB_RR_EN defined: round-robin. On a tie, the port not granted last wins. The pointer updates on every grant. First tie after reset goes to port 0.
- MEM_ARB_RR_EN undefined: fixed priority, and port 0 always wins a tie. The pointer is not implemented.

## Structure
- Package mem_arb_pkg holds the state enum (IDLE/BUSY/RESP), the port-id constants PORT_CPU = 0 and PORT_AUX = 1, and the default widths.
- Sub-module mem_arb_pick: a combinational 2-way picker. It takes req0, req1 and the last pointer and produces a winner id and a valid flag. The round-robin branch is inside the MEM_ARB_RR_EN guard.
- Top module: FSM, request latches, rdata_q, output muxing.

## Test plan
- Single write then read: port 0 writes addr 1 = 2, then reads addr 1. Required: gnt0 at +1, rvalid0 at +2; the read returns 2 with err0 = 0; port 1 outputs stay 0.
- Tie, round-robin build: both ports request together continuously. Grants alternate 0,1,0,1, and mem_we is never high outside BUSY. With the macro off, port 0 is granted every time while it requests.
- Out of range: port 1 writes addr 256 = 0xDEAD, then reads addr 256. Both complete with err1 = 1. The read returns rdata1 = 0, mem_we stays 0, and a port 0 read of addr 0 is unchanged.
- Back-to-back: port 0 writes addr 3 = 4, and port 1 writes addr 5 = 6 during the RESP of the first. BUSY follows RESP directly. Subsequent reads return 4 and 6.
- Reset mid-transaction: RST is asserted in the BUSY cycle of a write of addr 7 = 9. There is no rvalid, the FSM is IDLE next cycle, and a later read of addr 7 returns 9.
- Idle: no requests for 20 cycles. All outputs stay 0 and the FSM stays in IDLE.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the Mem_Datos arbiter: FSM states, port ids, default widths.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    typedef logic port_id_t;

    localparam port_id_t PORT_CPU = 1'b0;
    localparam port_id_t PORT_AUX = 1'b1;

    localparam int DEF_ADDR_W    = 32;
    localparam int DEF_DATA_W    = 32;
    localparam int DEF_MEM_WORDS = 256;

endpackage

// File: rtl/mem_arb_pick.sv
// Two-way request picker; MEM_ARB_RR_EN selects round-robin tie-break, otherwise port 0 wins ties.
// Latency: combinational, zero cycles.
// Backpressure: none; the loser simply keeps requesting.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic     req0,
    input  logic     req1,
`ifdef MEM_ARB_RR_EN
    input  port_id_t last,
`endif
    output port_id_t win_id,
    output logic     win_vld
);

    always_comb begin
        win_vld = req0 | req1;
        win_id  = PORT_CPU;
`ifdef MEM_ARB_RR_EN
        // On a tie the port that was not granted last time goes first.
        if (req0 && req1) begin
            win_id = (last == PORT_CPU) ? PORT_AUX : PORT_CPU;
        end else if (req1) begin
            win_id = PORT_AUX;
        end
`else
        if (!req0 && req1) begin
            win_id = PORT_AUX;
        end
`endif
    end

endmodule

// File: rtl/mem_datos_arbiter.sv
// Shares single-port Mem_Datos between the load/store unit (port 0) and an aux master (port 1); MEM_ARB_RR_EN = round-robin ties.
// Latency: req sampled at E0, gnt during E0..E1, rvalid during E1..E2; one transaction per two cycles, RESP->BUSY back-to-back.
// Backpressure: requesters hold req until their gnt; the losing port waits, a req still high in RESP is a new request.
module mem_datos_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int MEM_WORDS = DEF_MEM_WORDS
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              err0,
    output logic              err1,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata
);

    arb_state_t        state_q;
    port_id_t          port_q;
    logic              we_q;
    logic              in_range_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;

    port_id_t          win_id;
    logic              win_vld;
    logic              sel_we;
    logic              sel_in_range;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

`ifdef MEM_ARB_RR_EN
    port_id_t          last_q;
`endif

    mem_arb_pick u_pick (
        .req0    (req0),
        .req1    (req1),
`ifdef MEM_ARB_RR_EN
        .last    (last_q),
`endif
        .win_id  (win_id),
        .win_vld (win_vld)
    );

    always_comb begin
        sel_we    = we0;
        sel_addr  = addr0;
        sel_wdata = wdata0;
        if (win_id == PORT_AUX) begin
            sel_we    = we1;
            sel_addr  = addr1;
            sel_wdata = wdata1;
        end
    end

    // Widen both sides so the bound check cannot wrap for narrow address buses.
    assign sel_in_range = (64'(sel_addr) < 64'(MEM_WORDS));

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= IDLE;
            port_q     <= PORT_CPU;
            we_q       <= 1'b0;
            in_range_q <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
`ifdef MEM_ARB_RR_EN
            last_q     <= PORT_AUX;
`endif
        end else begin
            case (state_q)
                IDLE, RESP: begin
                    if (win_vld) begin
                        state_q    <= BUSY;
                        port_q     <= win_id;
                        we_q       <= sel_we;
                        in_range_q <= sel_in_range;
                        addr_q     <= sel_addr;
                        wdata_q    <= sel_wdata;
`ifdef MEM_ARB_RR_EN
                        last_q     <= win_id;
`endif
                    end else begin
                        state_q <= IDLE;
                    end
                end
                BUSY: begin
                    // Writes and out-of-range reads return zero, so only in-range reads keep memory data.
                    rdata_q <= (!we_q && in_range_q) ? mem_rdata : '0;
                    state_q <= RESP;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    logic busy;
    logic resp;

    assign busy = (state_q == BUSY);
    assign resp = (state_q == RESP);

    assign gnt0    = busy && (port_q == PORT_CPU);
    assign gnt1    = busy && (port_q == PORT_AUX);
    assign rvalid0 = resp && (port_q == PORT_CPU);
    assign rvalid1 = resp && (port_q == PORT_AUX);
    assign err0    = rvalid0 && !in_range_q;
    assign err1    = rvalid1 && !in_range_q;
    assign rdata0  = rvalid0 ? rdata_q : '0;
    assign rdata1  = rvalid1 ? rdata_q : '0;

    assign mem_addr  = busy ? addr_q  : '0;
    assign mem_wdata = busy ? wdata_q : '0;
    assign mem_we    = busy && we_q && in_range_q;

endmodule

// File: tb/tb_mem_datos_arbiter.sv
// Directed plus randomized bench for mem_datos_arbiter with a Mem_Datos stand-in and a spec-level reference model.
// Honours MEM_ARB_RR_EN for the expected tie-break.
module tb_mem_datos_arbiter;
    import mem_arb_pkg::*;

    localparam int WORDS = 256;

    typedef struct packed {
        logic        gnt0;
        logic        gnt1;
        logic        rv0;
        logic        rv1;
        logic        e0;
        logic        e1;
        logic        mem_we;
        logic [31:0] rd0;
        logic [31:0] rd1;
        logic [31:0] mem_addr;
        logic [31:0] mem_wdata;
    } obs_t;

    logic        CLK;
    logic        RST;
    logic        req0, we0, req1, we1;
    logic [31:0] addr0, wdata0, addr1, wdata1;
    logic        gnt0, gnt1, rvalid0, rvalid1, err0, err1, mem_we;
    logic [31:0] rdata0, rdata1, mem_addr, mem_wdata, mem_rdata;

    logic [31:0] mem     [WORDS];
    logic [31:0] ref_mem [WORDS];
    int          checks;
    int          errors;
`ifdef MEM_ARB_RR_EN
    logic        last_gnt;
`endif

    mem_datos_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_WORDS(WORDS)) dut (
        .CLK(CLK), .RST(RST),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata0(rdata0), .rdata1(rdata1), .err0(err0), .err1(err1),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_rdata(mem_rdata)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Mem_Datos stand-in; upper address bits fold into the read so an out-of-range read is visibly nonzero.
    always @(posedge CLK) if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
    assign mem_rdata = mem[mem_addr[7:0]] | {8'h00, mem_addr[31:8]};

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    function automatic obs_t observe();
        return '{gnt0, gnt1, rvalid0, rvalid1, err0, err1, mem_we, rdata0, rdata1, mem_addr, mem_wdata};
    endfunction

    function automatic string fmt(input obs_t o);
        return $sformatf("gnt=%b%b rvalid=%b%b err=%b%b rdata=%h/%h mem_we=%b mem_addr=%h mem_wdata=%h",
                         o.gnt0, o.gnt1, o.rv0, o.rv1, o.e0, o.e1, o.rd0, o.rd1, o.mem_we, o.mem_addr, o.mem_wdata);
    endfunction

    function automatic logic in_range(input logic [31:0] a);
        return a < WORDS;
    endfunction

    function automatic obs_t busy_exp(input logic p, input logic w, input logic [31:0] a, input logic [31:0] d);
        obs_t o = '0;
        o.gnt0      = (p == 1'b0);
        o.gnt1      = (p == 1'b1);
        o.mem_addr  = a;
        o.mem_wdata = d;
        o.mem_we    = w && in_range(a);
        return o;
    endfunction

    function automatic obs_t resp_exp(input logic p, input logic w, input logic [31:0] a);
        obs_t        o = '0;
        logic [31:0] rd;
        rd = (!w && in_range(a)) ? ref_mem[a[7:0]] : 32'h0;
        if (p == 1'b0) begin
            o.rv0 = 1'b1; o.e0 = !in_range(a); o.rd0 = rd;
        end else begin
            o.rv1 = 1'b1; o.e1 = !in_range(a); o.rd1 = rd;
        end
        return o;
    endfunction

    function automatic logic pick(input logic r0, input logic r1);
`ifdef MEM_ARB_RR_EN
        if (r0 && r1) return ~last_gnt;
`endif
        return r0 ? 1'b0 : (r1 ? 1'b1 : 1'b0);
    endfunction

    function automatic logic [31:0] rand_addr();
        return ($urandom_range(0, 7) == 0) ? 32'(256 + $urandom_range(0, 40)) : 32'($urandom_range(0, 15));
    endfunction

    task automatic chk(input string tag, input obs_t exp);
        obs_t got;
        got = observe();
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got [%s] required [%s]", tag, fmt(got), fmt(exp));
        end
    endtask

    task automatic chk_idle_state(input string tag);
        checks++;
        assert (dut.state_q === IDLE) else begin
            errors++;
            $error("FAIL %s: state got %0d required %0d", tag, dut.state_q, IDLE);
        end
    endtask

    task automatic idle_cycles(input string tag, input int n);
        repeat (n) begin
            @(posedge CLK); #1;
            chk(tag, '0);
        end
    endtask

    task automatic do_reset(input string tag);
        RST = 1'b1; req0 = 1'b0; req1 = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        chk(tag, '0);
        RST = 1'b0;
`ifdef MEM_ARB_RR_EN
        last_gnt = 1'b1;
`endif
    endtask

    // One grant from the current request lines: BUSY checked at +1, RESP at +2; returns inside RESP.
    task automatic run_grant(input string tag, input logic drop);
        logic        p, w;
        logic [31:0] a, d;
        p = pick(req0, req1);
        w = p ? we1 : we0;
        a = p ? addr1 : addr0;
        d = p ? wdata1 : wdata0;
        @(posedge CLK); #1;
        chk({tag, "/busy"}, busy_exp(p, w, a, d));
        if (drop) begin
            if (p) req1 = 1'b0; else req0 = 1'b0;
        end
`ifdef MEM_ARB_RR_EN
        last_gnt = p;
`endif
        if (w && in_range(a)) ref_mem[a[7:0]] = d;
        @(posedge CLK); #1;
        chk({tag, "/resp"}, resp_exp(p, w, a));
    endtask

    task automatic set0(input logic w, input logic [31:0] a, input logic [31:0] d);
        req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d;
    endtask

    task automatic set1(input logic w, input logic [31:0] a, input logic [31:0] d);
        req1 = 1'b1; we1 = w; addr1 = a; wdata1 = d;
    endtask

    initial begin
        int mode;
        int gap;
        checks = 0; errors = 0;
        RST = 1'b1;
        req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
        req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
        for (int i = 0; i < WORDS; i++) begin
            mem[i] = 32'h0; ref_mem[i] = 32'h0;
        end
        do_reset("reset");
        chk_idle_state("reset_state");

        // Single write then read on port 0.
        set0(1'b1, 32'd1, 32'd2);
        run_grant("wr1", 1'b1);
        idle_cycles("wr1/idle", 1);
        set0(1'b0, 32'd1, 32'd0);
        run_grant("rd1", 1'b1);
        idle_cycles("rd1/idle", 1);

        // Ties with both ports requesting continuously.
        do_reset("tie/reset");
        set0(1'b0, 32'd1, 32'd0);
        set1(1'b0, 32'd2, 32'd0);
        for (int i = 0; i < 6; i++) run_grant("tie", 1'b0);
        req0 = 1'b0; req1 = 1'b0;
        idle_cycles("tie/idle", 1);

        // Out-of-range accesses on port 1; addr 0 is the alias a stray write would hit.
        set0(1'b1, 32'd0, 32'h1234);
        run_grant("oor/seed", 1'b1);
        set1(1'b1, 32'd256, 32'hDEAD);
        run_grant("oor/wr", 1'b1);
        set1(1'b0, 32'd256, 32'h0);
        run_grant("oor/rd", 1'b1);
        set0(1'b0, 32'd0, 32'h0);
        run_grant("oor/rd0", 1'b1);
        idle_cycles("oor/idle", 1);

        // Back-to-back: port 1 raises its request during port 0's RESP.
        set0(1'b1, 32'd3, 32'd4);
        run_grant("b2b/wr0", 1'b1);
        set1(1'b1, 32'd5, 32'd6);
        run_grant("b2b/wr1", 1'b1);
        set0(1'b0, 32'd3, 32'd0);
        run_grant("b2b/rd0", 1'b1);
        set1(1'b0, 32'd5, 32'd0);
        run_grant("b2b/rd1", 1'b1);
        idle_cycles("b2b/idle", 1);

        // Reset in BUSY: the write still commits, no rvalid follows.
        set0(1'b1, 32'd7, 32'd9);
        @(posedge CLK); #1;
        chk("rstbusy/busy", busy_exp(1'b0, 1'b1, 32'd7, 32'd9));
        RST = 1'b1; req0 = 1'b0;
        ref_mem[7] = 32'd9;
        @(posedge CLK); #1;
        chk("rstbusy/after", '0);
        RST = 1'b0;
        chk_idle_state("rstbusy/state");
`ifdef MEM_ARB_RR_EN
        last_gnt = 1'b1;
`endif
        set0(1'b0, 32'd7, 32'd0);
        run_grant("rstbusy/rd", 1'b1);

        // Reset in RESP: the pulse already checked, everything zero next cycle.
        RST = 1'b1;
        @(posedge CLK); #1;
        chk("rstresp/after", '0);
        RST = 1'b0;
`ifdef MEM_ARB_RR_EN
        last_gnt = 1'b1;
`endif

        // Idle for 20 cycles.
        idle_cycles("idle", 20);
        chk_idle_state("idle_state");

        // Randomized traffic, including ties, out-of-range addresses and back-to-back requests.
        for (int i = 0; i < 60; i++) begin
            mode = $urandom_range(0, 2);
            if (mode != 1) set0(1'($urandom_range(0, 1)), rand_addr(), $urandom());
            if (mode != 0) set1(1'($urandom_range(0, 1)), rand_addr(), $urandom());
            run_grant("rand", 1'b1);
            if (req0 || req1) run_grant("rand/second", 1'b1);
            gap = $urandom_range(0, 2);
            idle_cycles("rand/idle", gap);
        end
        idle_cycles("end/idle", 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
